// File: rtl/regfile_pkg.sv
// Shared constants for the decode-stage register file: MIPS register names,
// link register and pending-counter defaults.
package regfile_pkg;

    localparam int REG_ZERO = 0;
    localparam int REG_AT   = 1;
    localparam int REG_V0   = 2;
    localparam int REG_V1   = 3;
    localparam int REG_A0   = 4;
    localparam int REG_A1   = 5;
    localparam int REG_A2   = 6;
    localparam int REG_A3   = 7;
    localparam int REG_T0   = 8;
    localparam int REG_T1   = 9;
    localparam int REG_T2   = 10;
    localparam int REG_T3   = 11;
    localparam int REG_T4   = 12;
    localparam int REG_T5   = 13;
    localparam int REG_T6   = 14;
    localparam int REG_T7   = 15;
    localparam int REG_S0   = 16;
    localparam int REG_S1   = 17;
    localparam int REG_S2   = 18;
    localparam int REG_S3   = 19;
    localparam int REG_S4   = 20;
    localparam int REG_S5   = 21;
    localparam int REG_S6   = 22;
    localparam int REG_S7   = 23;
    localparam int REG_T8   = 24;
    localparam int REG_T9   = 25;
    localparam int REG_K0   = 26;
    localparam int REG_K1   = 27;
    localparam int REG_GP   = 28;
    localparam int REG_SP   = 29;
    localparam int REG_FP   = 30;
    localparam int REG_RA   = 31;

    localparam int LINK_REG_DEFAULT = REG_RA;
    localparam int CNT_W_DEFAULT    = 2;

    // Largest number of in-flight writes a counter of the given width can track.
    function automatic int cnt_max(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/pending_counter.sv
// Saturating up/down counter tracking in-flight writes to one register.
module pending_counter
    import regfile_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             nonzero
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));

    // Simultaneous issue and retire cancel; both ends saturate.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            count <= '0;
        end else if (inc && !dec && count != MAX) begin
            count <= count + 1'b1;
        end else if (dec && !inc && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign full    = (count == MAX);
    assign nonzero = (count != '0);

`ifndef SYNTHESIS
    // A retire with nothing pending means the pipeline lost track of a write.
    retire_at_zero: assert property (@(posedge Clk) disable iff (Rst)
        !(dec && !inc && count == '0));
`endif

endmodule

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with same-cycle write/link bypass and a
// per-register pending-write scoreboard for hazard detection.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int NREGS          = 32,
    parameter int AW             = 5,
    parameter int NREAD          = 2,
    parameter int CNT_W          = CNT_W_DEFAULT,
    parameter int LINK_REG       = LINK_REG_DEFAULT,
    parameter bit ZERO_HARDWIRED = 1'b1
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [NREAD*AW-1:0]     RdAddr,
    output logic [NREAD*DATA_W-1:0] RdData,
    output logic [NREAD-1:0]        RdBusy,
    input  logic                    IssueValid,
    input  logic [AW-1:0]           IssueDest,
    output logic                    IssueFull,
    input  logic                    WriteEnb,
    input  logic [AW-1:0]           WriteReg,
    input  logic [DATA_W-1:0]       WriteData,
    input  logic                    WriteSuppress,
    input  logic                    LinkEnb,
    input  logic [DATA_W-1:0]       LinkData
);

    localparam logic [AW-1:0] LINK_ADDR = AW'(LINK_REG);

    logic [DATA_W-1:0] regs [NREGS];
    logic [CNT_W-1:0]  cnt  [NREGS];
    logic [NREGS-1:0]  cnt_full;
    logic [NREGS-1:0]  cnt_nonzero;
    logic [NREGS-1:0]  inc_vec;
    logic [NREGS-1:0]  dec_vec;

    logic data_write;
    logic link_write;
    logic retire_issue_dest;

    function automatic logic is_zero_reg(input logic [AW-1:0] a);
        return ZERO_HARDWIRED && (a == '0);
    endfunction

    assign data_write        = WriteEnb && !WriteSuppress && !is_zero_reg(WriteReg);
    assign link_write        = LinkEnb && !is_zero_reg(LINK_ADDR);
    assign retire_issue_dest = WriteEnb && (WriteReg == IssueDest);

    // A saturated counter can still accept an issue when a retire frees a slot.
    assign IssueFull = cnt_full[IssueDest] && !retire_issue_dest;

    for (genvar r = 0; r < NREGS; r++) begin : g_cnt
        localparam bit TIED_OFF = ZERO_HARDWIRED && (r == 0);

        assign inc_vec[r] = !TIED_OFF && IssueValid && !IssueFull && (IssueDest == AW'(r));
        assign dec_vec[r] = !TIED_OFF && WriteEnb && (WriteReg == AW'(r));

        pending_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .Clk     (Clk),
            .Rst     (Rst),
            .inc     (inc_vec[r]),
            .dec     (dec_vec[r]),
            .count   (cnt[r]),
            .full    (cnt_full[r]),
            .nonzero (cnt_nonzero[r])
        );
    end

    // Link is assigned last so it wins a collision with write-back.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            if (data_write) begin
                regs[WriteReg] <= WriteData;
            end
            if (link_write) begin
                regs[LINK_ADDR] <= LinkData;
            end
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;
        logic              retiring_last;

        assign addr = RdAddr[i*AW +: AW];

        always_comb begin
            data = regs[addr];
            if (is_zero_reg(addr)) begin
                data = '0;
            end else if (LinkEnb && addr == LINK_ADDR) begin
                data = LinkData;
            end else if (WriteEnb && !WriteSuppress && addr == WriteReg) begin
                data = WriteData;
            end
        end

        // The final outstanding write retiring now makes the operand available.
        assign retiring_last = WriteEnb && (WriteReg == addr) && (cnt[addr] == CNT_W'(1));

        assign RdData[i*DATA_W +: DATA_W] = data;
        assign RdBusy[i] = cnt_nonzero[addr] && !retiring_last;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the decode-stage register file.
- Provides NREAD combinational read ports, one write-back port and one immediate link-write port (jal).
- Write-to-read bypass is done in the same cycle, so no negedge write is needed.
- Per-register pending-write scoreboard lets the hazard logic stall on true dependences instead of decoding opcodes.
- Sits in the decode stage between the control unit and the ID/EX pipeline register.

Parameters:
- DATA_W, 32, register width in bits.
- NREGS, 32, number of architectural registers (power of two).
- AW, 5, register address width; must equal log2(NREGS).
- NREAD, 2, number of read ports.
- CNT_W, 2, width of per-register pending counter; at most 2^CNT_W-1 in-flight writes per register.
- LINK_REG, 31, register written by the link port.
- ZERO_HARDWIRED, 1, 1 = register 0 reads 0 and ignores writes.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Rst  in  1  synchronous active-high reset.
- RdAddr  in  NREAD*AW  packed read addresses; port i = bits [i*AW +: AW].
- RdData  out  NREAD*DATA_W  packed read data, combinational.
- RdBusy  out  NREAD  port i's register has a pending write (count != 0).
- IssueValid  in  1  an instruction writing IssueDest leaves decode this cycle.
- IssueDest  in  AW  destination register of the issuing instruction.
- IssueFull  out  1  IssueDest counter is saturated; hazard unit must stall.
- WriteEnb  in  1  write-back valid; retires one pending write.
- WriteReg  in  AW  write-back destination.
- WriteData  in  DATA_W  write-back data.
- WriteSuppress  in  1  retire without updating data (ALU overflow).
- LinkEnb  in  1  jal link write this cycle.
- LinkData  in  DATA_W  value written to LINK_REG (PC+4 is computed by the caller).

Behaviour:
- Reset: on posedge Clk with Rst=1, all registers and all pending counters are cleared to 0. RdData reads 0 and RdBusy/IssueFull are 0 from the next cycle. Rst overrides every same-cycle write, link or issue.
- Register write: on posedge, reg[WriteReg] <= WriteData when WriteEnb & ~WriteSuppress & ~(ZERO_HARDWIRED & WriteReg==0).
- Link write: on posedge with LinkEnb, reg[LINK_REG] <= LinkData. The link write does not touch the scoreboard.
- Write/link collision: if a write-back and a link write target the same register in the same cycle, the link write wins. The write-back still retires its pending count.
- Read bypass, per port, combinational, in priority order:
  1. Register 0 with ZERO_HARDWIRED returns 0.
  2. If LinkEnb and RdAddr==LINK_REG, return LinkData.
  3. If WriteEnb & ~WriteSuppress and RdAddr==WriteReg, return WriteData.
  4. Otherwise return the array value.
- Scoreboard: per-register count cnt[r].
  - Increment when IssueValid & IssueDest==r & ~IssueFull.
  - Decrement when WriteEnb & WriteReg==r; a suppressed write still decrements.
  - If both happen to the same register in one cycle, the count is unchanged.
  - Register 0 with ZERO_HARDWIRED never counts.
- IssueFull = cnt[IssueDest] == 2^CNT_W-1 and no same-cycle retire of IssueDest. An issue while IssueFull is ignored; the caller must not issue.
- Decrement at zero (retire with no pending entry) is a protocol error. The count holds at 0, and a simulation-only assertion fires.
- RdBusy[i] = cnt[RdAddr_i] != 0 and not (retiring this cycle with cnt==1). It is combinational and consistent with the bypass.
- Latency: writes are visible on the read ports in the same cycle via bypass, and from the array on the next cycle. Scoreboard updates are visible the next cycle.
- No other state. The block has no FSM; the sequential state is the register array and the counter array.

Decomposition:
- Shared package regfile_pkg holds:
  - the MIPS register-name constants (zero, at, …, ra);
  - LINK_REG default 31;
  - the CNT_W default.
- Sub-module pending_counter: one saturating up/down counter with inc, dec, full and nonzero outputs. It is instantiated NREGS times via generate.
- Read-port bypass muxes are built by a generate loop in the top module; no separate module.

Test Plan:
- Reset: write reg5=0x1234, assert Rst for 1 cycle -> RdAddr0=5 returns 0x00000000, RdBusy=0, all counters 0.
- Write bypass: WriteEnb, WriteReg=8, WriteData=0xDEADBEEF, RdAddr1=8 in the same cycle -> RdData1=0xDEADBEEF that cycle and the next with WriteEnb=0.
- Zero register and suppression: write reg0=0xFFFFFFFF -> reads 0. WriteSuppress=1 on reg9=7 (previous value 3) -> reads 3 and cnt[9] decrements.
- Scoreboard: issue dest 10 three times (CNT_W=2) -> IssueFull=1 on the 4th attempt and cnt stays 3. Retire ×3 -> RdBusy for reg10 falls in the retire cycle of the 3rd write. Issue+retire of reg10 in one cycle -> count unchanged.
- Link collision: LinkEnb, LinkData=0x00400008, WriteEnb, WriteReg=31, WriteData=0x55 -> reg31=0x00400008 and the bypass read returns 0x00400008.
- Parametrisation: NREAD=4, DATA_W=64, NREGS=64/AW=6 -> four ports read distinct regs 0x3F,1,2,3 with correct 64-bit values and independent RdBusy bits.
